// File: rtl/spinnaker_fpgas_reg_bank_pkg.sv
// spinnaker_fpgas_reg_bank_pkg: address map, reset values and CTRL bit positions
package spinnaker_fpgas_reg_bank_pkg;
  localparam int unsigned VERS_ADDR = 0;
  localparam int unsigned FLAG_ADDR = 1;
  localparam int unsigned CTRL_ADDR = 2;
  localparam int unsigned STAT_ADDR = 3;
  localparam int unsigned CH_BASE = 16;
  localparam int unsigned CH_STRIDE = 4;
  localparam int unsigned SKEY_OFF = 0;
  localparam int unsigned SMSK_OFF = 1;
  localparam int unsigned AKEY_OFF = 2;
  localparam int unsigned CNT_OFF = 3;
  localparam logic [31:0] KEY_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] MASK_RST = 32'h0000_0000;
  localparam logic EN_RST = 1'b1;
  localparam logic [31:0] UNMAPPED_RD = 32'hFFFF_FFFF;
  localparam int unsigned CTRL_APPLY_BIT = 0;
  localparam int unsigned CTRL_EN_LSB = 16;
endpackage

// File: rtl/spinnaker_fpgas_reg_bank_ch.sv
// spinnaker_fpgas_reg_bank_ch: one channel's shadow/active key-mask pair and saturating match counter
module spinnaker_fpgas_reg_bank_ch
  import spinnaker_fpgas_reg_bank_pkg::*;
#(
  parameter int CNT_BITS = 32
) (
  input  logic                CLK_IN,
  input  logic                RESET_N_IN,
  input  logic                wr_skey,
  input  logic                wr_smsk,
  input  logic                wr_cnt,
  input  logic                apply,
  input  logic                en,
  input  logic                match,
  input  logic [31:0]         wdata,
  output logic [31:0]         skey,
  output logic [31:0]         smsk,
  output logic [31:0]         akey,
  output logic [31:0]         amsk,
  output logic [CNT_BITS-1:0] cnt,
  output logic                sat
);
  // a counted pulse that finds the counter already full flags saturation
  assign sat = match && en && (&cnt);
  // shadow registers take bus writes
  always_ff @(posedge CLK_IN or negedge RESET_N_IN)
    if (!RESET_N_IN) begin
      skey <= KEY_RST;
      smsk <= MASK_RST;
    end else begin
      if (wr_skey) skey <= wdata;
      if (wr_smsk) smsk <= wdata;
    end
  // active route copies the pre-edge shadow on apply so it is never half-updated
  always_ff @(posedge CLK_IN or negedge RESET_N_IN)
    if (!RESET_N_IN) begin
      akey <= KEY_RST;
      amsk <= MASK_RST;
    end else if (apply) begin
      akey <= skey;
      amsk <= smsk;
    end
  // saturating match counter; a bus clear beats a simultaneous match
  always_ff @(posedge CLK_IN or negedge RESET_N_IN)
    if (!RESET_N_IN) cnt <= '0;
    else if (wr_cnt) cnt <= '0;
    else if (match && en && !(&cnt)) cnt <= cnt + CNT_BITS'(1);
endmodule

// File: rtl/spinnaker_fpgas_reg_bank_multi.sv
// spinnaker_fpgas_reg_bank_multi: control/diagnostic register bank driving NUM_CH multicast routing channels
module spinnaker_fpgas_reg_bank_multi
  import spinnaker_fpgas_reg_bank_pkg::*;
#(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32,
  parameter int NUM_CH    = 4,
  parameter int CNT_BITS  = 32
) (
  input  logic                   CLK_IN,
  input  logic                   RESET_N_IN,
  input  logic                   WRITE_IN,
  input  logic [REGA_BITS-1:0]   ADDR_IN,
  input  logic [REGD_BITS-1:0]   WRITE_DATA_IN,
  output logic [REGD_BITS-1:0]   READ_DATA_OUT,
  input  logic [31:0]            VERSION_IN,
  input  logic [3:0]             FLAGS_IN,
  input  logic [NUM_CH-1:0]      MATCH_IN,
  output logic [32*NUM_CH-1:0]   PERIPH_MC_KEY,
  output logic [32*NUM_CH-1:0]   PERIPH_MC_MASK,
  output logic [NUM_CH-1:0]      CH_EN_OUT
);
  logic [REGA_BITS-1:0] ch_rel;
  logic                 in_ch;
  logic [1:0]           off;
  logic                 wr_ctrl;
  logic                 wr_stat;
  logic                 apply;
  logic [NUM_CH-1:0]    ch_hit;
  logic [NUM_CH-1:0]    sat;
  logic [NUM_CH-1:0]    stat;
  logic [31:0]          ch_rd [NUM_CH];
  logic [REGD_BITS-1:0] rd_next;
  assign ch_rel = ADDR_IN - REGA_BITS'(CH_BASE);
  assign in_ch = ADDR_IN >= REGA_BITS'(CH_BASE) && ADDR_IN < REGA_BITS'(CH_BASE + CH_STRIDE * NUM_CH);
  assign off = ch_rel[1:0];
  assign wr_ctrl = WRITE_IN && ADDR_IN == REGA_BITS'(CTRL_ADDR);
  assign wr_stat = WRITE_IN && ADDR_IN == REGA_BITS'(STAT_ADDR);
  assign apply = wr_ctrl && WRITE_DATA_IN[CTRL_APPLY_BIT];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [31:0]         skey;
    logic [31:0]         smsk;
    logic [CNT_BITS-1:0] cnt;
    assign ch_hit[i] = in_ch && ch_rel[REGA_BITS-1:2] == (REGA_BITS-2)'(i);
    spinnaker_fpgas_reg_bank_ch #(.CNT_BITS(CNT_BITS)) u_ch (
      .CLK_IN    (CLK_IN),
      .RESET_N_IN(RESET_N_IN),
      .wr_skey   (WRITE_IN && ch_hit[i] && off == 2'(SKEY_OFF)),
      .wr_smsk   (WRITE_IN && ch_hit[i] && off == 2'(SMSK_OFF)),
      .wr_cnt    (WRITE_IN && ch_hit[i] && off == 2'(CNT_OFF)),
      .apply     (apply),
      .en        (CH_EN_OUT[i]),
      .match     (MATCH_IN[i]),
      .wdata     (WRITE_DATA_IN),
      .skey      (skey),
      .smsk      (smsk),
      .akey      (PERIPH_MC_KEY[32*i +: 32]),
      .amsk      (PERIPH_MC_MASK[32*i +: 32]),
      .cnt       (cnt),
      .sat       (sat[i])
    );
    assign ch_rd[i] = off == 2'(SKEY_OFF) ? skey :
                      off == 2'(SMSK_OFF) ? smsk :
                      off == 2'(AKEY_OFF) ? PERIPH_MC_KEY[32*i +: 32] : 32'(cnt);
  end
  // channel enables and sticky saturation flags; a new saturation beats a same-cycle clear
  always_ff @(posedge CLK_IN or negedge RESET_N_IN)
    if (!RESET_N_IN) begin
      CH_EN_OUT <= {NUM_CH{EN_RST}};
      stat <= '0;
    end else begin
      if (wr_ctrl) CH_EN_OUT <= WRITE_DATA_IN[CTRL_EN_LSB +: NUM_CH];
      stat <= (stat & ~(wr_stat ? WRITE_DATA_IN[NUM_CH-1:0] : '0)) | sat;
    end
  // read mux over the pre-edge state; APPLY always reads back as zero
  always_comb begin
    rd_next = UNMAPPED_RD;
    if (ADDR_IN == REGA_BITS'(VERS_ADDR)) rd_next = VERSION_IN;
    else if (ADDR_IN == REGA_BITS'(FLAG_ADDR)) rd_next = REGD_BITS'(FLAGS_IN);
    else if (ADDR_IN == REGA_BITS'(CTRL_ADDR)) begin
      rd_next = '0;
      rd_next[CTRL_EN_LSB +: NUM_CH] = CH_EN_OUT;
    end
    else if (ADDR_IN == REGA_BITS'(STAT_ADDR)) rd_next = REGD_BITS'(stat);
    else for (int i = 0; i < NUM_CH; i++) if (ch_hit[i]) rd_next = ch_rd[i];
  end
  // registered read data, one cycle after the address
  always_ff @(posedge CLK_IN or negedge RESET_N_IN)
    if (!RESET_N_IN) READ_DATA_OUT <= '0;
    else READ_DATA_OUT <= rd_next;
endmodule

// File: tb/tb_spinnaker_fpgas_reg_bank_multi.sv
// tb_spinnaker_fpgas_reg_bank_multi: random and directed checks against a behavioural register-bank model
module tb_spinnaker_fpgas_reg_bank_multi;
  localparam int NCH = 4;
  localparam int CMAX = 15;
  logic          CLK_IN = 0;
  logic          RESET_N_IN = 0;
  logic          WRITE_IN = 0;
  logic [13:0]   ADDR_IN = 0;
  logic [31:0]   WRITE_DATA_IN = 0;
  logic [31:0]   READ_DATA_OUT;
  logic [31:0]   VERSION_IN = 32'h1234_5678;
  logic [3:0]    FLAGS_IN = 4'hA;
  logic [3:0]    MATCH_IN = 0;
  logic [127:0]  PERIPH_MC_KEY;
  logic [127:0]  PERIPH_MC_MASK;
  logic [3:0]    CH_EN_OUT;
  int checks = 0;
  int failures = 0;
  bit chk_on = 0;
  logic [31:0] m_skey [NCH];
  logic [31:0] m_smsk [NCH];
  logic [31:0] m_akey [NCH];
  logic [31:0] m_amsk [NCH];
  int          m_cnt  [NCH];
  logic [3:0]  m_en;
  logic [3:0]  m_stat;
  logic [31:0] m_rd;

  spinnaker_fpgas_reg_bank_multi #(.REGA_BITS(14), .REGD_BITS(32), .NUM_CH(NCH), .CNT_BITS(4)) dut (
    .CLK_IN(CLK_IN), .RESET_N_IN(RESET_N_IN), .WRITE_IN(WRITE_IN), .ADDR_IN(ADDR_IN),
    .WRITE_DATA_IN(WRITE_DATA_IN), .READ_DATA_OUT(READ_DATA_OUT), .VERSION_IN(VERSION_IN),
    .FLAGS_IN(FLAGS_IN), .MATCH_IN(MATCH_IN), .PERIPH_MC_KEY(PERIPH_MC_KEY),
    .PERIPH_MC_MASK(PERIPH_MC_MASK), .CH_EN_OUT(CH_EN_OUT)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_skey[i] = 32'hFFFF_FFFF;
      m_smsk[i] = 0;
      m_akey[i] = 32'hFFFF_FFFF;
      m_amsk[i] = 0;
      m_cnt[i] = 0;
    end
    m_en = 4'hF;
    m_stat = 0;
    m_rd = 0;
  endtask

  function automatic logic [31:0] mread(int a);
    if (a == 0) return VERSION_IN;
    if (a == 1) return {28'h0, FLAGS_IN};
    if (a == 2) return {12'h0, m_en, 16'h0};
    if (a == 3) return {28'h0, m_stat};
    if (a >= 16 && a < 16 + 4 * NCH) begin
      int c = (a - 16) / 4;
      case ((a - 16) % 4)
        0: return m_skey[c];
        1: return m_smsk[c];
        2: return m_akey[c];
        default: return 32'(m_cnt[c]);
      endcase
    end
    return 32'hFFFF_FFFF;
  endfunction

  task automatic mstep(bit w, int a, logic [31:0] d, logic [3:0] m);
    logic [3:0] en0 = m_en;
    logic [3:0] clr_st = 0;
    logic [3:0] clr_c = 0;
    logic [3:0] sat = 0;
    m_rd = mread(a);
    if (w) begin
      if (a == 2) begin
        if (d[0]) for (int i = 0; i < NCH; i++) begin
          m_akey[i] = m_skey[i];
          m_amsk[i] = m_smsk[i];
        end
        m_en = d[19:16];
      end else if (a == 3) clr_st = d[3:0];
      else if (a >= 16 && a < 16 + 4 * NCH) begin
        int c = (a - 16) / 4;
        int o = (a - 16) % 4;
        if (o == 0) m_skey[c] = d;
        else if (o == 1) m_smsk[c] = d;
        else if (o == 3) clr_c[c] = 1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (m[i] && en0[i]) begin
        if (m_cnt[i] == CMAX) sat[i] = 1;
        else m_cnt[i]++;
      end
      if (clr_c[i]) m_cnt[i] = 0;
    end
    m_stat = (m_stat & ~clr_st) | sat;
  endtask

  task automatic step(bit w, int a, logic [31:0] d, logic [3:0] m);
    #1;
    WRITE_IN = w;
    ADDR_IN = 14'(a);
    WRITE_DATA_IN = d;
    MATCH_IN = m;
    mstep(w, a, d, m);
    @(negedge CLK_IN);
  endtask

  task automatic rd_chk(string n, int a, logic [31:0] exp);
    step(0, a, 0, 0);
    chk(n, READ_DATA_OUT, exp);
  endtask

  // every falling edge: outputs must equal the model's view
  always @(negedge CLK_IN) if (chk_on) begin
    logic [127:0] ek;
    logic [127:0] em;
    for (int i = 0; i < NCH; i++) begin
      ek[32*i +: 32] = m_akey[i];
      em[32*i +: 32] = m_amsk[i];
    end
    chk("rdata", READ_DATA_OUT, m_rd);
    chk("key", PERIPH_MC_KEY, ek);
    chk("mask", PERIPH_MC_MASK, em);
    chk("en", CH_EN_OUT, m_en);
  end

  initial begin
    m_reset();
    repeat (2) @(negedge CLK_IN);
    RESET_N_IN = 1;
    chk_on = 1;
    chk("rst_en", CH_EN_OUT, 4'hF);
    chk("rst_rd", READ_DATA_OUT, 0);
    chk("rst_key", PERIPH_MC_KEY, {128{1'b1}});
    chk("rst_mask", PERIPH_MC_MASK, 0);
    rd_chk("vers", 0, 32'h1234_5678);
    rd_chk("flag", 1, 32'h0000_000A);
    rd_chk("ctrl", 2, 32'h000F_0000);
    for (int c = 0; c < NCH; c++) begin
      rd_chk("skey_rst", 16 + 4 * c, 32'hFFFF_FFFF);
      rd_chk("smsk_rst", 17 + 4 * c, 32'h0);
      rd_chk("akey_rst", 18 + 4 * c, 32'hFFFF_FFFF);
      rd_chk("cnt_rst", 19 + 4 * c, 32'h0);
    end
    rd_chk("unmapped", 100, 32'hFFFF_FFFF);
    step(1, 20, 32'h1234_0000, 0);
    step(1, 21, 32'hFFFF_0000, 0);
    chk("ch1_key_pending", PERIPH_MC_KEY[63:32], 32'hFFFF_FFFF);
    step(1, 2, 32'h000F_0001, 0);
    chk("ch1_key_applied", PERIPH_MC_KEY[63:32], 32'h1234_0000);
    chk("ch1_mask_applied", PERIPH_MC_MASK[63:32], 32'hFFFF_0000);
    rd_chk("ctrl_apply_reads0", 2, 32'h000F_0000);
    step(1, 16, 32'hAAAA_0000, 0);
    chk("ch0_key_pending", PERIPH_MC_KEY[31:0], 32'hFFFF_FFFF);
    step(1, 2, 32'h000F_0001, 0);
    chk("ch0_key_applied", PERIPH_MC_KEY[31:0], 32'hAAAA_0000);
    repeat (17) step(0, 0, 0, 4'b0100);
    rd_chk("cnt2_sat", 27, 32'd15);
    rd_chk("stat_sat", 3, 32'h4);
    step(1, 3, 32'h4, 0);
    rd_chk("stat_w1c", 3, 32'h0);
    step(1, 3, 32'h4, 4'b0100);
    rd_chk("stat_set_wins", 3, 32'h4);
    step(0, 0, 0, 4'b0010);
    step(1, 2, 32'h0001_0000, 0);
    step(0, 0, 0, 4'b0010);
    rd_chk("cnt1_disabled", 23, 32'd1);
    step(0, 0, 0, 4'b0001);
    step(1, 19, 32'h0, 4'b0001);
    rd_chk("cnt0_clear_wins", 19, 32'h0);
    step(1, 16, 32'h0000_0055, 0);
    #1 RESET_N_IN = 0;
    m_reset();
    #1;
    chk("async_rst_key", PERIPH_MC_KEY, {128{1'b1}});
    chk("async_rst_mask", PERIPH_MC_MASK, 0);
    chk("async_rst_en", CH_EN_OUT, 4'hF);
    chk("async_rst_rd", READ_DATA_OUT, 0);
    @(negedge CLK_IN);
    RESET_N_IN = 1;
    step(1, 2, 32'h0000_0001, 0);
    chk("bare_apply_key", PERIPH_MC_KEY, {128{1'b1}});
    step(1, 2, 32'h000F_0000, 0);
    for (int n = 0; n < 800; n++) begin
      int r = $urandom_range(0, 9);
      int a = r < 2 ? $urandom_range(0, 3) : r < 7 ? $urandom_range(16, 31) :
              r < 8 ? $urandom_range(4, 15) : $urandom_range(32, 16383);
      step($urandom_range(0, 2) == 0, a, $urandom, 4'($urandom_range(0, 15)));
    end
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
